// File: rtl/proc_control_unit.sv
// Multi-cycle control FSM for the 16-bit register-file/bus datapath.
// Define MVNZ_EN to enable the conditional move (opcode 0100, mvnz).
module proc_control_unit #(
    parameter int IR_W  = 10,
    parameter int CNT_W = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             run,
    input  logic [15:0]      din,
    input  logic             g_nz,
    output logic [IR_W-1:0]  ir,
    output logic [7:0]       rin,
    output logic [7:0]       rout,
    output logic             gout,
    output logic             dinout,
    output logic             irin,
    output logic             ain,
    output logic             gin,
    output logic             addsub,
    output logic             done,
    output logic             busy,
    output logic [CNT_W-1:0] icount
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_EXEC1 = 3'd2,
        S_EXEC2 = 3'd3,
        S_EXEC3 = 3'd4
    } state_t;

    localparam logic [3:0] OP_MV   = 4'b0000;
    localparam logic [3:0] OP_MVI  = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_SUB  = 4'b0011;
    localparam logic [3:0] OP_MVNZ = 4'b0100;

    state_t state;
    state_t state_nxt;

    logic [3:0] opcode;
    logic [2:0] reg_x;
    logic [2:0] reg_y;
    logic [7:0] sel_x;
    logic [7:0] sel_y;
    logic       is_mv;
    logic       is_mvi;
    logic       is_alu;
    logic       is_sub;
    logic       is_mvnz;
    logic       unused_din;

    assign opcode = ir[3:0];
    assign reg_x  = ir[6:4];
    assign reg_y  = ir[9:7];

    // Only the low IR_W bits of din reach the instruction register;
    // the full word is consumed by the datapath as an immediate.
    assign unused_din = ^din[15:IR_W];

    // One-hot register selects for the X and Y fields.
    assign sel_x = 8'h01 << reg_x;
    assign sel_y = 8'h01 << reg_y;

    assign is_mv  = (opcode == OP_MV);
    assign is_mvi = (opcode == OP_MVI);
    assign is_sub = (opcode == OP_SUB);
    assign is_alu = (opcode == OP_ADD) || is_sub;

`ifdef MVNZ_EN
    assign is_mvnz = (opcode == OP_MVNZ);
`else
    logic unused_gnz;
    assign is_mvnz    = 1'b0;
    assign unused_gnz = g_nz;
`endif

    // Next-state and strobe decode from the current state and ir.
    always_comb begin
        state_nxt = state;
        rin       = 8'h00;
        rout      = 8'h00;
        gout      = 1'b0;
        dinout    = 1'b0;
        irin      = 1'b0;
        ain       = 1'b0;
        gin       = 1'b0;
        addsub    = 1'b0;
        done      = 1'b0;
        busy      = (state != S_IDLE);

        unique case (state)
            S_IDLE: begin
                if (run) begin
                    state_nxt = S_FETCH;
                end
            end
            S_FETCH: begin
                irin      = 1'b1;
                state_nxt = S_EXEC1;
            end
            S_EXEC1: begin
                if (is_alu) begin
                    rout      = sel_x;
                    ain       = 1'b1;
                    state_nxt = S_EXEC2;
                end else begin
                    done = 1'b1;
                    if (is_mv) begin
                        rout = sel_y;
                        rin  = sel_x;
                    end else if (is_mvi) begin
                        dinout = 1'b1;
                        rin    = sel_x;
                    end else if (is_mvnz) begin
                        rout = sel_y;
                        rin  = g_nz ? sel_x : 8'h00;
                    end
                end
            end
            S_EXEC2: begin
                rout      = sel_y;
                gin       = 1'b1;
                addsub    = is_sub;
                state_nxt = S_EXEC3;
            end
            S_EXEC3: begin
                gout = 1'b1;
                rin  = sel_x;
                done = 1'b1;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase

        // Every instruction ends by chaining to the next fetch or idling.
        if (done) begin
            state_nxt = run ? S_FETCH : S_IDLE;
        end
    end

    // State register; reset abandons any partial instruction.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Instruction register, captured during FETCH.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ir <= '0;
        end else if (irin) begin
            ir <= din[IR_W-1:0];
        end
    end

    // Retired-instruction counter, free-running wrap.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            icount <= '0;
        end else if (done) begin
            icount <= icount + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

endmodule

// File: tb/tb_proc_control_unit.sv
// Scoreboard bench for proc_control_unit: expected per-cycle strobes
// are queued as instructions are driven, then drained and compared.
module tb_proc_control_unit;

    logic        clock;
    logic        reset;
    logic        run;
    logic [15:0] din;
    logic        g_nz;
    logic [9:0]  ir;
    logic [7:0]  rin;
    logic [7:0]  rout;
    logic        gout;
    logic        dinout;
    logic        irin;
    logic        ain;
    logic        gin;
    logic        addsub;
    logic        done;
    logic        busy;
    logic [15:0] icount;

    logic        run2;
    logic [15:0] din2;
    logic [9:0]  ir2;
    logic [7:0]  rin2;
    logic [7:0]  rout2;
    logic        gout2;
    logic        dinout2;
    logic        irin2;
    logic        ain2;
    logic        gin2;
    logic        addsub2;
    logic        done2;
    logic        busy2;
    logic [2:0]  icount2;

    int tests;
    int fails;
    int exp_icount;

    logic [23:0] exp_q[$];
    logic [23:0] obs_q[$];
    logic [23:0] obs_now;

    assign obs_now = {busy, done, irin, dinout, gout, ain, gin, addsub,
                      rin, rout};

    proc_control_unit #(.IR_W(10), .CNT_W(16)) dut (
        .clock(clock), .reset(reset), .run(run), .din(din), .g_nz(g_nz),
        .ir(ir), .rin(rin), .rout(rout), .gout(gout), .dinout(dinout),
        .irin(irin), .ain(ain), .gin(gin), .addsub(addsub), .done(done),
        .busy(busy), .icount(icount)
    );

    // Narrow counter instance so the wrap is reachable in a few cycles.
    proc_control_unit #(.IR_W(10), .CNT_W(3)) dut_wrap (
        .clock(clock), .reset(reset), .run(run2), .din(din2), .g_nz(1'b0),
        .ir(ir2), .rin(rin2), .rout(rout2), .gout(gout2), .dinout(dinout2),
        .irin(irin2), .ain(ain2), .gin(gin2), .addsub(addsub2),
        .done(done2), .busy(busy2), .icount(icount2)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [23:0] vec(
        input logic b, input logic d, input logic fi, input logic di,
        input logic go, input logic a, input logic g, input logic s,
        input logic [7:0] ri, input logic [7:0] ro);
        return {b, d, fi, di, go, a, g, s, ri, ro};
    endfunction

    task automatic idle_cycle(input logic r);
        exp_q.push_back(24'h0);
        @(negedge clock);
        run = r;
        #1 obs_q.push_back(obs_now);
    endtask

    task automatic run_instr(input logic [15:0] word, input logic [15:0] imm,
                             input logic gnz, input logic next_run);
        logic [3:0] op;
        logic [7:0] one;
        logic [7:0] mx;
        logic [7:0] my;
        int n;
        op  = word[3:0];
        one = 8'h01;
        mx  = one << word[6:4];
        my  = one << word[9:7];
        exp_q.push_back(vec(1, 0, 1, 0, 0, 0, 0, 0, 8'h00, 8'h00));
        case (op)
            4'd0: begin
                exp_q.push_back(vec(1, 1, 0, 0, 0, 0, 0, 0, mx, my));
                n = 2;
            end
            4'd1: begin
                exp_q.push_back(vec(1, 1, 0, 1, 0, 0, 0, 0, mx, 8'h00));
                n = 2;
            end
            4'd2, 4'd3: begin
                exp_q.push_back(vec(1, 0, 0, 0, 0, 1, 0, 0, 8'h00, mx));
                exp_q.push_back(vec(1, 0, 0, 0, 0, 0, 1, op[0], 8'h00, my));
                exp_q.push_back(vec(1, 1, 0, 0, 1, 0, 0, 0, mx, 8'h00));
                n = 4;
            end
`ifdef MVNZ_EN
            4'd4: begin
                exp_q.push_back(vec(1, 1, 0, 0, 0, 0, 0, 0,
                                    gnz ? mx : 8'h00, my));
                n = 2;
            end
`endif
            default: begin
                exp_q.push_back(vec(1, 1, 0, 0, 0, 0, 0, 0, 8'h00, 8'h00));
                n = 2;
            end
        endcase
        exp_icount = exp_icount + 1;
        for (int i = 0; i < n; i++) begin
            @(negedge clock);
            din  = (i == 0) ? word : imm;
            g_nz = gnz;
            run  = (i == n - 1) ? next_run : 1'b1;
            #1 obs_q.push_back(obs_now);
        end
    endtask

    task automatic test_reset;
        logic [23:0] e;
        logic [23:0] o;
        reset = 1'b1;
        run   = 1'b0;
        run2  = 1'b0;
        din   = 16'h0;
        din2  = 16'h000F;
        g_nz  = 1'b0;
        exp_icount = 0;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        repeat (5) idle_cycle(1'b0);
        for (int k = 0; exp_q.size() > 0; k++) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            tests++;
            if (o !== e) begin
                fails++;
                $display("FAIL reset_idle cyc%0d got %h want %h", k, o, e);
            end
        end
        tests++;
        if (icount !== 16'h0) begin
            fails++;
            $display("FAIL reset_icount got %h want 0", icount);
        end
        tests++;
        if (ir !== 10'h0) begin
            fails++;
            $display("FAIL reset_ir got %h want 0", ir);
        end
    endtask

    task automatic test_mvi;
        logic [23:0] e;
        logic [23:0] o;
        idle_cycle(1'b1);
        run_instr(16'h0031, 16'h00A5, 1'b0, 1'b0);
        idle_cycle(1'b0);
        for (int k = 0; exp_q.size() > 0; k++) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            tests++;
            if (o !== e) begin
                fails++;
                $display("FAIL mvi cyc%0d got %h want %h", k, o, e);
            end
        end
        tests++;
        if (icount !== 16'(exp_icount)) begin
            fails++;
            $display("FAIL mvi_icount got %0d want %0d", icount, exp_icount);
        end
        tests++;
        if (ir !== 10'h031) begin
            fails++;
            $display("FAIL mvi_ir got %h want 031", ir);
        end
    endtask

    task automatic test_add_sub;
        logic [23:0] e;
        logic [23:0] o;
        idle_cycle(1'b1);
        run_instr(16'h0112, 16'h0, 1'b0, 1'b1);
        run_instr(16'h0113, 16'h0, 1'b0, 1'b0);
        idle_cycle(1'b0);
        for (int k = 0; exp_q.size() > 0; k++) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            tests++;
            if (o !== e) begin
                fails++;
                $display("FAIL add_sub cyc%0d got %h want %h", k, o, e);
            end
        end
        tests++;
        if (icount !== 16'(exp_icount)) begin
            fails++;
            $display("FAIL add_sub_icount got %0d want %0d",
                     icount, exp_icount);
        end
    endtask

    task automatic test_back_to_back;
        logic [23:0] e;
        logic [23:0] o;
        idle_cycle(1'b1);
        run_instr(16'h00A0, 16'h0, 1'b0, 1'b1);
        run_instr(16'h0242, 16'h0, 1'b0, 1'b1);
        run_instr(16'h03F0, 16'h0, 1'b0, 1'b1);
        run_instr(16'h020F, 16'h0, 1'b0, 1'b0);
        idle_cycle(1'b0);
        idle_cycle(1'b0);
        for (int k = 0; exp_q.size() > 0; k++) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            tests++;
            if (o !== e) begin
                fails++;
                $display("FAIL back_to_back cyc%0d got %h want %h", k, o, e);
            end
        end
        tests++;
        if (icount !== 16'(exp_icount)) begin
            fails++;
            $display("FAIL b2b_icount got %0d want %0d", icount, exp_icount);
        end
        tests++;
        if (ir !== 10'h20F) begin
            fails++;
            $display("FAIL b2b_ir got %h want 20f", ir);
        end
    endtask

    task automatic test_mvnz;
        logic [23:0] e;
        logic [23:0] o;
        idle_cycle(1'b1);
        run_instr(16'h0354, 16'h0, 1'b1, 1'b1);
        run_instr(16'h0354, 16'h0, 1'b0, 1'b0);
        idle_cycle(1'b0);
        for (int k = 0; exp_q.size() > 0; k++) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            tests++;
            if (o !== e) begin
                fails++;
                $display("FAIL mvnz cyc%0d got %h want %h", k, o, e);
            end
        end
        g_nz = 1'b0;
    endtask

    task automatic test_reset_mid;
        @(negedge clock);
        run = 1'b1;
        @(negedge clock);
        din = 16'h0112;
        @(negedge clock);
        din = 16'h0;
        @(negedge clock);
        #1;
        tests++;
        if (gin !== 1'b1 || rout !== 8'h04) begin
            fails++;
            $display("FAIL mid_exec2 got gin=%b rout=%h want 1 04", gin, rout);
        end
        reset = 1'b1;
        #1;
        tests++;
        if (obs_now !== 24'h0) begin
            fails++;
            $display("FAIL mid_reset_strobes got %h want 0", obs_now);
        end
        tests++;
        if (ir !== 10'h0 || icount !== 16'h0) begin
            fails++;
            $display("FAIL mid_reset_regs got ir=%h icount=%h want 0 0",
                     ir, icount);
        end
        @(negedge clock);
        #1;
        tests++;
        if (rin !== 8'h00 || done !== 1'b0) begin
            fails++;
            $display("FAIL mid_reset_hold got rin=%h done=%b want 0 0",
                     rin, done);
        end
        reset = 1'b0;
        run   = 1'b0;
        exp_icount = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clock);
            #1;
            tests++;
            if (obs_now !== 24'h0) begin
                fails++;
                $display("FAIL post_reset_idle cyc%0d got %h want 0",
                         k, obs_now);
            end
        end
    endtask

    task automatic test_wrap;
        tests++;
        if (icount2 !== 3'd0) begin
            fails++;
            $display("FAIL wrap_start got %0d want 0", icount2);
        end
        @(negedge clock);
        run2 = 1'b1;
        repeat (15) @(negedge clock);
        #1;
        tests++;
        if (icount2 !== 3'd7) begin
            fails++;
            $display("FAIL wrap_max got %0d want 7", icount2);
        end
        repeat (2) @(negedge clock);
        #1;
        tests++;
        if (icount2 !== 3'd0) begin
            fails++;
            $display("FAIL wrap_zero got %0d want 0", icount2);
        end
        run2 = 1'b0;
    endtask

    initial begin
        tests = 0;
        fails = 0;
        test_reset();
        test_mvi();
        test_add_sub();
        test_back_to_back();
        test_mvnz();
        test_reset_mid();
        test_wrap();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
